// File: rtl/ahb_arb_pkg.sv
// Shared encodings, state type and burst-length helper for the AHB bus arbiter.
// ARB_LOCK_EN adds the LOCKED state to the arbiter state type.
package ahb_arb_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_BURST
`ifdef ARB_LOCK_EN
    ,
    ST_LOCKED
`endif
  } arb_state_e;

  // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [CNT_W-1:0] burst_beats_m1(input logic [2:0] hburst);
    logic [CNT_W-1:0] v_len;
    v_len = '0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  v_len = CNT_W'(3);
      HBURST_WRAP8,  HBURST_INCR8:  v_len = CNT_W'(7);
      HBURST_WRAP16, HBURST_INCR16: v_len = CNT_W'(15);
      default:                      v_len = '0;
    endcase
    return v_len;
  endfunction

  function automatic logic is_fixed_burst(input logic [2:0] hburst);
    return (burst_beats_m1(hburst) != '0);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first requester after i_ptr, wrapping at N.
module rr_priority_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_valid_c
);

  always_comb begin
    logic [IW-1:0] w_cand;
    w_cand    = '0;
    o_gnt_c   = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    // Candidates ordered ptr+1 .. ptr+N; the last one is the pointer itself.
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(i_ptr) + k) % N);
      if (!o_valid_c && i_req[w_cand]) begin
        o_gnt_c[w_cand] = 1'b1;
        o_idx_c         = w_cand;
        o_valid_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter with fixed-burst hold in front of the APB bridge.
// ARB_LOCK_EN enables HLOCK handling and the LOCKED state; otherwise HMASTLOCK is 0.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  localparam int unsigned IW = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [IW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  arb_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IW-1:0]          r_ptr;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_hmaster;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic [NUM_MASTERS-1:0] w_win_gnt;
  logic [IW-1:0]          w_win_idx;
  logic                   w_burst_start;
  logic                   w_arb;
  arb_state_e             w_arb_state;
  arb_state_e             w_err_state;

  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .i_req     (HBUSREQ),
    .i_ptr     (r_ptr),
    .o_gnt_c   (w_pick_gnt),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  // Idle bus parks on the default master.
  assign w_win_gnt = w_pick_valid ? w_pick_gnt : DEF_GNT;
  assign w_win_idx = w_pick_valid ? w_pick_idx : DEF_IDX;

  assign w_burst_start = (HTRANS == HTRANS_NONSEQ) && is_fixed_burst(HBURST);

  // Which accepted transfers are arbitration points.
  always_comb begin
    w_arb = 1'b0;
    if (HREADY) begin
      case (r_state)
        ST_OPEN:  w_arb = !w_burst_start;
        ST_BURST: w_arb = ((HTRANS == HTRANS_SEQ) && (r_cnt == CNT_W'(1))) ||
                          (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ);
        default:  w_arb = 1'b0;
      endcase
    end
  end

`ifdef ARB_LOCK_EN
  logic r_hmastlock;

  assign w_arb_state = HLOCK[w_win_idx] ? ST_LOCKED : ST_OPEN;
  assign w_err_state = ((r_state == ST_LOCKED) && HLOCK[r_ptr]) ? ST_LOCKED : ST_OPEN;
  assign HMASTLOCK   = r_hmastlock;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hmastlock <= 1'b0;
    end else if (HREADY) begin
      r_hmastlock <= HLOCK[r_ptr];
    end
  end
`else
  logic w_unused_lock;

  assign w_arb_state   = ST_OPEN;
  assign w_err_state   = ST_OPEN;
  assign HMASTLOCK     = 1'b0;
  assign w_unused_lock = ^HLOCK;
`endif

  // Arbiter FSM, beat counter, grant and address-phase owner.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_OPEN;
      r_cnt     <= '0;
      r_ptr     <= DEF_IDX;
      r_grant   <= DEF_GNT;
      r_hmaster <= DEF_IDX;
    end else if (!HREADY) begin
      if (HRESP == HRESP_ERROR) begin
        r_cnt   <= '0;
        r_state <= w_err_state;
      end
    end else begin
      r_hmaster <= r_ptr;
      if (w_arb) begin
        r_ptr   <= w_win_idx;
        r_grant <= w_win_gnt;
      end
      case (r_state)
        ST_OPEN: begin
          if (w_burst_start) begin
            r_state <= ST_BURST;
            r_cnt   <= burst_beats_m1(HBURST);
          end else begin
            r_state <= w_arb_state;
          end
        end
        ST_BURST: begin
          if (HTRANS == HTRANS_SEQ) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= w_arb_state;
            end
          end else if (HTRANS != HTRANS_BUSY) begin
            r_cnt   <= '0;
            r_state <= w_arb_state;
          end
        end
`ifdef ARB_LOCK_EN
        ST_LOCKED: begin
          r_cnt <= '0;
          if (!HLOCK[r_ptr]) begin
            r_state <= ST_OPEN;
          end
        end
`endif
        default: begin
          r_cnt   <= '0;
          r_state <= ST_OPEN;
        end
      endcase
    end
  end

  assign HGRANT  = r_grant;
  assign HMASTER = r_hmaster;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model of the arbitration rules.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         HRESETn;
  logic [N-1:0] HBUSREQ, HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(clk), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the grant, who owns the address phase, and what hold is active.
  int m_own, m_hm, m_left;
  bit m_hml;
  int m_mode;  // 0 open, 1 burst hold, 2 lock hold

  function automatic int beats(input logic [2:0] b);
    if (b == 3'd2 || b == 3'd3) return 4;
    if (b == 3'd4 || b == 3'd5) return 8;
    if (b == 3'd6 || b == 3'd7) return 16;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return DEF;
  endfunction

  task automatic model_step();
    bit arb;
    if (!HREADY) begin
      if (HRESP == 2'b01) begin
        m_left = 0;
        if (!(m_mode == 2 && LOCK_EN && HLOCK[m_own])) m_mode = 0;
      end
      return;
    end
    m_hm  = m_own;
    m_hml = LOCK_EN && HLOCK[m_own];
    arb   = 1'b0;
    if (m_mode == 0) begin
      if (HTRANS == 2'b10 && beats(HBURST) > 0) begin
        m_mode = 1;
        m_left = beats(HBURST) - 1;
      end else arb = 1'b1;
    end else if (m_mode == 1) begin
      if (HTRANS == 2'b11) begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; arb = 1'b1; end
      end else if (HTRANS != 2'b01) begin
        m_left = 0; m_mode = 0; arb = 1'b1;
      end
    end else if (!HLOCK[m_own]) begin
      m_mode = 0;
    end
    if (arb) begin
      m_own = rr_pick(HBUSREQ, m_own);
      if (LOCK_EN && HLOCK[m_own]) m_mode = 2;
    end
  endtask

  always @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      m_own = DEF; m_hm = DEF; m_hml = 1'b0; m_mode = 0; m_left = 0;
    end else begin
      model_step();
    end
  end

  // Model comparison on every out-of-reset cycle, away from the active edge.
  always @(negedge clk) begin
    if (HRESETn === 1'b1) begin
      chk("model_hgrant", 32'(HGRANT), 32'(1) << m_own);
      chk("model_hmaster", 32'(HMASTER), 32'(m_hm));
      chk("model_hmastlock", 32'(HMASTLOCK), 32'(m_hml));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic [1:0] rsp);
    HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g_alt [4];
    logic [1:0]   m_alt [4];
    g_alt = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    m_alt = '{2'd0, 2'd1, 2'd2, 2'd1};

    HRESETn = 1'b0;
    drive('0, '0, 2'b00, 3'd0, 1'b1, 2'b00);
    tick(); tick();
    chk("reset_hgrant", 32'(HGRANT), 32'h1);
    chk("reset_hmaster", 32'(HMASTER), 32'h0);
    chk("reset_hmastlock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;

    // Masters 1 and 2, all SINGLE: grants alternate, HMASTER one transfer behind.
    drive(4'b0110, '0, 2'b10, 3'd0, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_alt_grant", 32'(HGRANT), 32'(g_alt[i]));
      chk("single_alt_hmaster", 32'(HMASTER), 32'(m_alt[i]));
    end

    // Master 2 INCR8 with master 3 waiting, 5 wait states mid-burst.
    drive(4'b0100, '0, 2'b00, 3'd0, 1'b1, 2'b00);
    tick();
    chk("incr8_pre_grant", 32'(HGRANT), 32'h4);
    drive(4'b1100, '0, 2'b10, 3'd5, 1'b1, 2'b00);
    tick();
    chk("incr8_nonseq_grant", 32'(HGRANT), 32'h4);
    HTRANS = 2'b11;
    for (int b = 1; b <= 7; b++) begin
      if (b == 4) begin
        HREADY = 1'b0;
        for (int w = 0; w < 5; w++) begin
          tick();
          chk("wait_grant", 32'(HGRANT), 32'h4);
          chk("wait_hmaster", 32'(HMASTER), 32'h2);
        end
        HREADY = 1'b1;
      end
      tick();
      chk("incr8_beat_grant", 32'(HGRANT), (b < 7) ? 32'h4 : 32'h8);
    end

    // Master 1 WRAP4 terminated by IDLE after two beats.
    drive(4'b0010, '0, 2'b00, 3'd0, 1'b1, 2'b00);
    tick();
    chk("wrap4_pre_grant", 32'(HGRANT), 32'h2);
    drive(4'b0110, '0, 2'b10, 3'd2, 1'b1, 2'b00);
    tick();
    HTRANS = 2'b11;
    tick();
    chk("wrap4_beat2_grant", 32'(HGRANT), 32'h2);
    HTRANS = 2'b00;
    tick();
    chk("wrap4_early_term_grant", 32'(HGRANT), 32'h4);

    // ERROR during a wait state releases the burst hold.
    drive(4'b0010, '0, 2'b00, 3'd0, 1'b1, 2'b00);
    tick();
    drive(4'b0011, '0, 2'b10, 3'd7, 1'b1, 2'b00);
    tick();
    HTRANS = 2'b11;
    tick();
    chk("err_burst_grant", 32'(HGRANT), 32'h2);
    HREADY = 1'b0; HRESP = 2'b01;
    tick();
    chk("err_wait_grant", 32'(HGRANT), 32'h2);
    HREADY = 1'b1; HRESP = 2'b00; HTRANS = 2'b01;
    tick();
    chk("err_released_grant", 32'(HGRANT), 32'h1);

`ifdef ARB_LOCK_EN
    // Master 0 locks for 10 cycles while master 1 requests.
    drive(4'b0001, 4'b0001, 2'b00, 3'd0, 1'b1, 2'b00);
    tick();
    chk("lock_enter_grant", 32'(HGRANT), 32'h1);
    HBUSREQ = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lock_hold_grant", 32'(HGRANT), 32'h1);
      chk("lock_hmastlock", 32'(HMASTLOCK), 32'h1);
    end
    HLOCK = '0;
    tick();
    chk("lock_release_grant", 32'(HGRANT), 32'h1);
    chk("lock_release_hmastlock", 32'(HMASTLOCK), 32'h0);
    tick();
    chk("lock_after_grant", 32'(HGRANT), 32'h2);
`endif

    // Reset in the middle of an INCR16.
    drive(4'b0100, '0, 2'b00, 3'd0, 1'b1, 2'b00);
    tick();
    drive(4'b0100, '0, 2'b10, 3'd7, 1'b1, 2'b00);
    tick();
    HTRANS = 2'b11;
    tick(); tick(); tick();
    chk("incr16_grant", 32'(HGRANT), 32'h4);
    HRESETn = 1'b0;
    #1;
    chk("midreset_hgrant", 32'(HGRANT), 32'h1);
    chk("midreset_hmaster", 32'(HMASTER), 32'h0);
    chk("midreset_hmastlock", 32'(HMASTLOCK), 32'h0);
    tick();
    HRESETn = 1'b1;
    drive(4'b1000, '0, 2'b00, 3'd0, 1'b1, 2'b00);
    tick();
    chk("post_reset_grant", 32'(HGRANT), 32'h8);

    // Randomized traffic checked against the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] lk;
      lk = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      HREADY  = ($urandom_range(0, 3) != 0);
      HRESP   = (!HREADY && $urandom_range(0, 5) == 0) ? 2'b01 : 2'b00;
      HBUSREQ = N'($urandom);
      HLOCK   = lk;
      HTRANS  = 2'($urandom);
      HBURST  = 3'($urandom);
      if ($urandom_range(0, 400) == 0) begin
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB-Lite bus arbiter that shares the single AHB-to-APB bridge slave port between up to eight AHB masters. It issues one-hot grants, tracks fixed-length bursts so a burst is never split, and honours locked transfers. It drives the master-select used by the external address/control and write-data multiplexers feeding the bridge.

## Interface
- NUM_MASTERS, 4, number of requesting masters (2..8)
- DEFAULT_MASTER, 0, master granted when no requests are pending
- HCLK  input  1  bus clock; all state on rising edge
- HRESETn  input  1  asynchronous active-low reset
- HBUSREQ  input  NUM_MASTERS  per-master bus request
- HLOCK  input  NUM_MASTERS  per-master lock request
- HTRANS  input  2  transfer type on the muxed bus (current address-phase owner)
- HBURST  input  3  burst type on the muxed bus
- HREADY  input  1  bridge HREADYout; transfer accepted when 1
- HRESP  input  2  bridge response; 2'b01 = ERROR
- HGRANT  output  NUM_MASTERS  one-hot grant
- HMASTER  output  $clog2(NUM_MASTERS)  index of address-phase owner; drives bus muxes
- HMASTLOCK  output  1  current address phase is locked

## Operation
- Reset values: HGRANT = one-hot DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, beat counter = 0, round-robin pointer = DEFAULT_MASTER.
- States: OPEN (arbitration allowed), BURST (fixed-length burst in progress), LOCKED (owner holds lock).
- Arbitration point: rising edge with HREADY = 1 while in OPEN. Winner = first requester searching from (last granted + 1) modulo NUM_MASTERS; no requester -> DEFAULT_MASTER. Pointer updates to winner.
- OPEN -> BURST: HTRANS = NONSEQ accepted with HBURST in {INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16}; beat counter loads length-1 (3/7/15). No re-arbitration that edge.
- BURST: counter decrements on each accepted SEQ; BUSY holds count. Counter 0 -> OPEN. Accepted IDLE or NONSEQ while count > 0 (early termination) -> counter cleared, OPEN, arbitration on that edge.
- SINGLE and INCR: no hold; arbitration every accepted transfer.
- LOCKED: entered at an arbitration point where the winner has HLOCK = 1; grant held while that master's HLOCK = 1; HLOCK low seen with HREADY = 1 -> OPEN. Lock has priority over burst hold.
- HRESP = ERROR with HREADY = 0: beat counter cleared, state -> OPEN (or LOCKED if lock still held).
- Reset mid-burst or mid-lock: all state returns to reset values immediately.

## Timing
- HGRANT changes only at edges with HREADY = 1; never while HREADY = 0.
- HMASTER and HMASTLOCK register the granted index and its HLOCK at every edge with HREADY = 1; HMASTER therefore lags HGRANT by one accepted transfer.
- Request-to-grant latency: 1 cycle minimum when bus is OPEN and HREADY = 1.
- Worst-case wait without locks: (NUM_MASTERS-1) x 16 beats plus wait states.

## Configuration
- ARB_LOCK_EN defined: LOCKED state and HLOCK handling as above.
- ARB_LOCK_EN undefined: HLOCK ignored, LOCKED state absent, HMASTLOCK tied 0.

## Structure
- Package ahb_arb_pkg: HTRANS and HBURST encodings, HRESP ERROR constant, state enum, burst-length function.
- Sub-module rr_priority_picker: combinational round-robin search (request vector, pointer -> one-hot winner, valid).

## Test plan
- Masters 1 and 2 request, HREADY = 1, all SINGLE -> grants alternate 1,2,1,2; HMASTER follows one cycle later.
- Master 2 INCR8 with master 3 requesting -> HGRANT stays on 2 for 8 accepted beats, then moves to 3.
- Master 1 WRAP4, IDLE after beat 2 -> counter cleared, grant moves on that edge.
- HREADY = 0 for 5 cycles mid-burst -> HGRANT, HMASTER constant; ERROR response clears hold.
- With ARB_LOCK_EN, master 0 HLOCK = 1 for 10 cycles vs master 1 request -> HMASTLOCK = 1, grant held until HLOCK drops.
- HRESETn low mid-INCR16 -> HGRANT = one-hot DEFAULT_MASTER, HMASTLOCK = 0 immediately.
